// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial sequence detector.
// Contents:
//   calc_sw  - width of the State output for a given pattern length
//   kmp_next - next matched-prefix length after one new input bit
package seq_det_pkg;

  localparam int MAX_LEN = 16;
  localparam int MAX_SW  = 5;

  function automatic int calc_sw(input int n);
    return $clog2(n + 1);
  endfunction

  // pattern is right-aligned in a MAX_LEN vector; its bit n-1 is the
  // first bit expected on the serial input.
  function automatic logic [MAX_SW-1:0] kmp_next(
    input logic [MAX_LEN-1:0] pattern,
    input int                 n,
    input logic [MAX_SW-1:0]  s,
    input logic               b,
    input logic               overlap
  );
    logic [MAX_LEN:0]  t;    // tracked string, index 0 is the oldest bit
    logic [MAX_SW-1:0] res;
    logic              hit;
    int                cur;
    int                len;
    res = '0;
    cur = int'(s);
    if (cur > n) return '0;  // illegal state recovers to idle
    if (cur == n && !overlap) cur = 0;
    len = cur + 1;
    t = '0;
    for (int i = 0; i <= MAX_LEN; i++) begin
      if (i < cur)       t[i] = pattern[n-1-i];
      else if (i == cur) t[i] = b;
    end
    // Longest suffix of t that is also a pattern prefix; scan from the
    // longest candidate down so the first hit wins.
    for (int k = MAX_LEN; k >= 1; k--) begin
      if (res == '0 && k <= n && k <= len) begin
        hit = 1'b1;
        for (int j = 0; j < MAX_LEN; j++) begin
          if (j < k && t[len-k+j] != pattern[n-1-j]) hit = 1'b0;
        end
        if (hit) res = MAX_SW'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_det_next.sv
// Combinational next-state evaluation for seq_detector.
// Ports:
//   state      - current matched-prefix length
//   w          - serial input bit
//   pattern    - active pattern (MSB first on the wire)
//   next_state - matched-prefix length after w
//   next_full  - next_state equals the pattern length
module seq_det_next
  import seq_det_pkg::*;
#(
  parameter int PATTERN_LEN = 4,
  parameter int OVERLAP     = 1,
  parameter int SW          = calc_sw(PATTERN_LEN)
) (
  input  logic [SW-1:0]          state,
  input  logic                   w,
  input  logic [PATTERN_LEN-1:0] pattern,
  output logic [SW-1:0]          next_state,
  output logic                   next_full
);

  logic [MAX_SW-1:0] nxt;

  always_comb begin
    nxt        = kmp_next(MAX_LEN'(pattern), PATTERN_LEN, MAX_SW'(state), w,
                          OVERLAP != 0);
    next_state = SW'(nxt);
    next_full  = (int'(nxt) == PATTERN_LEN);
  end

endmodule

// File: rtl/seq_detector.sv
// Parametrised serial sequence detector with KMP fallback, Moore match
// flag, saturating match counter and run-time pattern reload.
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-high reset
//   w         - serial input bit, sampled when en=1
//   en        - advance enable
//   load      - pattern reload strobe, overrides en
//   pat_in    - pattern captured on load
//   State     - matched-prefix length, 0..PATTERN_LEN
//   z         - high while State equals PATTERN_LEN
//   match_cnt - saturating count of completed matches
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1101,
  parameter int                     OVERLAP     = 1,
  parameter int                     CNT_W       = 8,
  localparam int                    SW          = calc_sw(PATTERN_LEN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   w,
  input  logic                   en,
  input  logic                   load,
  input  logic [PATTERN_LEN-1:0] pat_in,
  output logic [SW-1:0]          State,
  output logic                   z,
  output logic [CNT_W-1:0]       match_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PATTERN_LEN-1:0] pattern;
  logic [SW-1:0]          next_state;
  logic                   next_full;

  seq_det_next #(
    .PATTERN_LEN(PATTERN_LEN),
    .OVERLAP    (OVERLAP),
    .SW         (SW)
  ) u_next (
    .state     (State),
    .w         (w),
    .pattern   (pattern),
    .next_state(next_state),
    .next_full (next_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      State     <= '0;
      match_cnt <= '0;
      pattern   <= PATTERN;
    end else if (load) begin
      State     <= '0;
      match_cnt <= '0;
      pattern   <= pat_in;
    end else if (en) begin
      State <= next_state;
      if (next_full && match_cnt != CNT_MAX) match_cnt <= match_cnt + 1'b1;
    end
  end

  assign z = (int'(State) == PATTERN_LEN);

endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised, binary-encoded serial sequence detector. It samples one bit `w` per enabled clock and tracks the longest matched prefix of an N-bit pattern. It asserts a Moore match flag `z` and keeps a saturating match count. The pattern is set by parameter at reset, can be reloaded at run time, and matching is either overlapping or non-overlapping. It is the general replacement for the fixed 3-bit hand-derived detector FSMs in the lab designs.

## Interface
Parameters:
- `PATTERN_LEN`, default 4: pattern length N. Legal range 2..16.
- `PATTERN`, default 4'b1101: reset-value pattern, PATTERN_LEN bits. The MSB is the first bit expected on `w`.
- `OVERLAP`, default 1: 1 = overlapping matches allowed; 0 = non-overlapping.
- `CNT_W`, default 8: width of the match counter.

Derived: SW = $clog2(PATTERN_LEN+1).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `w` in 1: serial input bit, sampled on edges where `en`=1.
- `en` in 1: advance enable. When low, `State` and the counter hold and `w` is ignored.
- `load` in 1: pattern reload strobe. Has priority over `en`.
- `pat_in` in PATTERN_LEN: new pattern, captured when `load`=1.
- `State` out SW: binary count of matched prefix bits, 0..N.
- `z` out 1: match flag, high while `State`==N.
- `match_cnt` out CNT_W: saturating count of completed matches.

## Operation
- State s is the number of leading pattern bits currently matched. The string being tracked is the first s pattern bits followed by the new bit b.
- Next state = length of the longest suffix of that string that equals a prefix of the pattern (KMP failure semantics). A mismatch therefore falls back to the longest usable partial match, not to 0.
- From s=N:
  - OVERLAP=1: the full pattern is used as the prefix, so shared suffix bits count toward the next match.
  - OVERLAP=0: s is treated as 0 before b is applied.
- `z` is decoded from `State` only. There is no combinational path from `w` to `z`.
- `match_cnt` increments on each enabled edge whose next state is N. At all-ones it saturates and holds.
- Load: on an edge with `load`=1:
  - the pattern register takes `pat_in`;
  - `State` goes to 0 and `match_cnt` clears to 0;
  - `w` is ignored on that edge, whatever the value of `en`.
- States with values greater than N are unreachable. If one is entered, it must go to 0 on the next enabled edge.

## Timing
- Reset, asynchronous and immediate:
  - `State`=0, `z`=0, `match_cnt`=0;
  - pattern register = `PATTERN`.
- Reset takes effect mid-sequence, discarding any partial match.
- Latency: `z` rises in the cycle after the edge that samples the final pattern bit, and stays high for exactly one enabled cycle per match. If `en` drops while `State`==N, `z` stays high until the next enabled edge.
- Priority per edge: reset > load > en > hold.
- Back-to-back loads are legal; each one restarts matching.

## Structure
- Package `seq_det_pkg` holds:
  - the SW derivation function;
  - a pure function `kmp_next(pattern, s, b, overlap)` that returns the next state.
- One combinational sub-module, `seq_det_next`. It evaluates `kmp_next` for the current `State`, `w` and pattern register, and its outputs are the next state and the "next is N" flag.
- The top level holds the state register, the pattern register and the saturating counter.

## Test plan
All scenarios use N=4, PATTERN=1101, CNT_W=8 unless stated.
- Overlap, OVERLAP=1. Input 1,1,0,1,1,0,1 with `en`=1:
  - `State` goes 1,2,3,4,2,3,4;
  - `z` is high after bits 4 and 7;
  - `match_cnt`=2.
- Non-overlap, OVERLAP=0. Same input:
  - `State` goes 1,2,3,4,1,0,1;
  - `z` is high only after bit 4;
  - `match_cnt`=1.
- Fallback. Input 1,1,1,0,1:
  - `State` goes 1,2,2,3,4;
  - `z` is high after bit 5.
- Enable and load:
  - Drive 1,1,0, then `en`=0 for 3 cycles with `w`=0: `State` holds at 3.
  - `en`=1 with `w`=1: `State`=4.
  - Pulse `load` with `pat_in`=0110: `State`=0, `match_cnt`=0.
  - Input 0,1,1,0: `z` goes high.
- Saturation. CNT_W=2, six non-overlapping matches: `match_cnt` stays at 3 after the third match.
- Async reset. Assert `reset` between clock edges while `State`=3: `State`=0, `z`=0 and `match_cnt`=0 immediately, and the pattern returns to 1101 even after an earlier load.
